// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and default sizing
// for the SPI master controller and its TX buffer.
package spi_pkg;

  localparam int SPI_D_PACK     = 8;
  localparam int SPI_DIV        = 4;
  localparam int SPI_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: small show-ahead TX word buffer,
// synchronous write/pop, FULL/EMPTY from an occupancy count.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int W     = SPI_D_PACK,
  parameter int DEPTH = SPI_FIFO_DEPTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [NW-1:0] N_FULL   = NW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == N_FULL);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // storage: data words need no reset, the count gates validity
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap at DEPTH; write+pop together keeps occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: frames buffered words for an SPI serializer,
// generating SCLK, chip-select ENABLE and a DONE pulse per frame.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int D_PACK     = SPI_D_PACK,
  parameter int DIV        = SPI_DIV,
  parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [D_PACK-1:0] WR_DATA,
  output logic              FULL,
  input  logic              C_POL,
  input  logic              C_PH,
  output logic              SCLK,
  output logic              ENABLE,
  output logic [D_PACK-1:0] DATA_OUT,
  output logic              C_PH_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW = $clog2(2 * D_PACK + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * D_PACK - 1);

  spi_state_e        state;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     edges;
  logic              cpol_q;
  logic              empty;
  logic              pop;
  logic              cnt_done;
  logic [D_PACK-1:0] head;

  assign pop      = (state == S_IDLE) && !empty;
  assign cnt_done = (cnt == CNT_LAST);

  spi_tx_fifo #(
    .W     (D_PACK),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (WR_EN),
    .wr_data (WR_DATA),
    .rd_en   (pop),
    .rd_data (head),
    .full    (FULL),
    .empty   (empty)
  );

  // frame sequencer: setup, 2*D_PACK SCLK edges, hold, gap
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      edges    <= '0;
      cpol_q   <= 1'b0;
      SCLK     <= 1'b0;
      ENABLE   <= 1'b1;
      DATA_OUT <= '0;
      C_PH_OUT <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          SCLK <= C_POL;
          cnt  <= '0;
          if (pop) begin
            DATA_OUT <= head;
            cpol_q   <= C_POL;
            C_PH_OUT <= C_PH;
            ENABLE   <= 1'b0;
            BUSY     <= 1'b1;
            edges    <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          SCLK <= cpol_q;
          if (cnt_done) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_done) begin
            cnt   <= '0;
            SCLK  <= ~SCLK;
            edges <= edges + 1'b1;
            if (edges == EDGE_LAST) state <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_done) begin
            cnt    <= '0;
            ENABLE <= 1'b1;
            DONE   <= 1'b1;
            state  <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_done) begin
            cnt   <= '0;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of framing, timing,
// FIFO buffering, polarity latch and abort on reset.
module tb_spi_master_ctrl;

  logic       CLK;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       C_POL;
  logic       C_PH;
  logic       SCLK;
  logic       ENABLE;
  logic [7:0] DATA_OUT;
  logic       C_PH_OUT;
  logic       BUSY;
  logic       DONE;

  logic       wr1;
  logic [7:0] wd1;
  logic       full1;
  logic       cpol1;
  logic       cph1;
  logic       sclk1;
  logic       en1;
  logic [7:0] dout1;
  logic       cph_o1;
  logic       busy1;
  logic       done1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cyc;
  int wr1_cyc;
  int dchg;

  int         fall_q[$];
  logic [7:0] dat_q[$];
  int         done_q[$];
  int         tog_q[$];
  int         f1_q[$];
  logic [7:0] d1_q[$];
  int         dn1_q[$];
  int         t1_q[$];

  logic       en_p   = 1'b1;
  logic       sclk_p = 1'b0;
  logic [7:0] dat_p  = 8'h00;
  logic       en1_p  = 1'b1;
  logic       sclk1_p = 1'b0;

  spi_master_ctrl u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .FULL     (FULL),
    .C_POL    (C_POL),
    .C_PH     (C_PH),
    .SCLK     (SCLK),
    .ENABLE   (ENABLE),
    .DATA_OUT (DATA_OUT),
    .C_PH_OUT (C_PH_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  spi_master_ctrl #(
    .D_PACK     (8),
    .DIV        (1),
    .FIFO_DEPTH (4)
  ) u_div1 (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (wr1),
    .WR_DATA  (wd1),
    .FULL     (full1),
    .C_POL    (cpol1),
    .C_PH     (cph1),
    .SCLK     (sclk1),
    .ENABLE   (en1),
    .DATA_OUT (dout1),
    .C_PH_OUT (cph_o1),
    .BUSY     (busy1),
    .DONE     (done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // event recorder, sampled on the falling edge
  always @(negedge CLK) begin
    if (en_p === 1'b1 && ENABLE === 1'b0) begin
      fall_q.push_back(cyc);
      dat_q.push_back(DATA_OUT);
    end
    if (DONE === 1'b1) done_q.push_back(cyc);
    if (SCLK !== sclk_p) tog_q.push_back(cyc);
    if (ENABLE === 1'b0 && en_p === 1'b0 && DATA_OUT !== dat_p)
      dchg++;
    en_p   = ENABLE;
    sclk_p = SCLK;
    dat_p  = DATA_OUT;
    if (en1_p === 1'b1 && en1 === 1'b0) begin
      f1_q.push_back(cyc);
      d1_q.push_back(dout1);
    end
    if (done1 === 1'b1) dn1_q.push_back(cyc);
    if (sclk1 !== sclk1_p) t1_q.push_back(cyc);
    en1_p   = en1;
    sclk1_p = sclk1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    fall_q.delete();
    dat_q.delete();
    done_q.delete();
    tog_q.delete();
    dchg = 0;
  endtask

  task automatic put(input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    @(posedge CLK);
    #1;
    wr_cyc  = cyc;
    WR_EN   = 1'b0;
  endtask

  task automatic put1(input logic [7:0] d);
    wr1 = 1'b1;
    wd1 = d;
    @(posedge CLK);
    #1;
    wr1_cyc = cyc;
    wr1 = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string tag, input int n, input int lim);
    int k = 0;
    while (done_q.size() < n && k < lim) begin
      @(negedge CLK);
      #1;
      k++;
    end
    chk(tag, 32'(done_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done1(input string tag, input int n, input int lim);
    int k = 0;
    while (dn1_q.size() < n && k < lim) begin
      @(negedge CLK);
      #1;
      k++;
    end
    chk(tag, 32'(dn1_q.size() >= n), 32'd1);
  endtask

  initial begin
    int e0;
    int e1;
    int nb;
    int k;
    logic [7:0] w;

    RST = 1'b1; WR_EN = 1'b0; WR_DATA = 8'h00;
    C_POL = 1'b1; C_PH = 1'b1;
    wr1 = 1'b0; wd1 = 8'h00; cpol1 = 1'b0; cph1 = 1'b0;
    step(3);
    chk("rst_enable", ENABLE, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_cph", C_PH_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_full", FULL, 0);
    RST = 1'b0;
    step(1);
    chk("idle_follow_pol", SCLK, 1);
    C_POL = 1'b0; C_PH = 1'b0;
    step(2);

    // single frame, DIV=4
    clr();
    put(8'hA5);
    step(30);
    chk("s1_busy_mid", BUSY, 1);
    chk("s1_en_mid", ENABLE, 0);
    chk("s1_data_mid", DATA_OUT, 32'hA5);
    wait_done("s1_done_seen", 1, 200);
    chk("s1_en_latency", fall_q[0] - wr_cyc, 1);
    chk("s1_done_time", done_q[0] - fall_q[0], 72);
    chk("s1_data", dat_q[0], 32'hA5);
    chk("s1_toggles", tog_q.size(), 16);
    chk("s1_first_tog", tog_q[0] - fall_q[0], 8);
    nb = 0;
    for (int i = 1; i < tog_q.size(); i++)
      if (tog_q[i] - tog_q[i-1] != 4) nb++;
    chk("s1_tog_spacing", nb, 0);
    chk("s1_data_stable", dchg, 0);
    chk("s1_sclk_end", SCLK, 0);
    step(1);
    chk("s1_done_pulse", DONE, 0);
    step(4);
    chk("s1_idle", BUSY, 0);

    // back-to-back frames
    clr();
    put(8'h01);
    put(8'h02);
    put(8'h03);
    wait_done("s2_done_seen", 3, 400);
    chk("s2_period_a", fall_q[1] - fall_q[0], 77);
    chk("s2_period_b", fall_q[2] - fall_q[1], 77);
    for (int i = 0; i < 3; i++) begin
      w = 8'(i + 1);
      chk("s2_order", dat_q[i], w);
    end
    step(8);

    // buffer fills, sixth write dropped
    clr();
    put(8'h11);
    put(8'h12);
    put(8'h13);
    put(8'h14);
    chk("s3_full_at4", FULL, 0);
    put(8'h15);
    chk("s3_full_at5", FULL, 1);
    put(8'h16);
    chk("s3_full_at6", FULL, 1);
    wait_done("s3_done_seen", 5, 600);
    step(100);
    chk("s3_frames", fall_q.size(), 5);
    chk("s3_full_end", FULL, 0);
    for (int i = 0; i < 5; i++) begin
      w = 8'(8'h11 + i);
      chk("s3_order", dat_q[i], w);
    end

    // CPOL=1/CPHA=1 latched, inputs change mid-frame
    C_POL = 1'b1; C_PH = 1'b1;
    step(3);
    chk("s4_idle_high", SCLK, 1);
    clr();
    put(8'h3C);
    step(1);
    chk("s4_setup_high", SCLK, 1);
    step(19);
    C_POL = 1'b0; C_PH = 1'b0;
    step(10);
    chk("s4_cph_mid", C_PH_OUT, 1);
    wait_done("s4_done_seen", 1, 200);
    chk("s4_sclk_end", SCLK, 1);
    chk("s4_cph_end", C_PH_OUT, 1);
    chk("s4_toggles", tog_q.size(), 16);
    chk("s4_done_time", done_q[0] - fall_q[0], 72);
    step(8);
    chk("s4_idle_follow", SCLK, 0);

    // reset mid-frame at the 7th SCLK toggle
    C_PH = 1'b1;
    step(2);
    clr();
    put(8'h77);
    put(8'h01);
    put(8'h02);
    put(8'h03);
    put(8'h04);
    chk("s5_full_pre", FULL, 1);
    k = 0;
    while (tog_q.size() < 7 && k < 200) begin
      @(negedge CLK);
      #1;
      k++;
    end
    chk("s5_tog7_seen", 32'(tog_q.size() >= 7), 1);
    RST = 1'b1;
    step(1);
    chk("s5_enable", ENABLE, 1);
    chk("s5_sclk", SCLK, 0);
    chk("s5_full", FULL, 0);
    chk("s5_done", DONE, 0);
    chk("s5_busy", BUSY, 0);
    chk("s5_cph", C_PH_OUT, 0);
    RST = 1'b0;
    C_PH = 1'b0;
    step(150);
    chk("s5_no_done", done_q.size(), 0);
    chk("s5_fifo_flushed", fall_q.size(), 1);

    // DIV=1 instance, two back-to-back frames
    f1_q.delete(); d1_q.delete(); dn1_q.delete(); t1_q.delete();
    put1(8'h5A);
    put1(8'hC3);
    wait_done1("s6_done_seen", 2, 100);
    e0 = f1_q[0];
    e1 = f1_q[1];
    chk("s6_en_latency", e0 - wr1_cyc + 1, 1);
    chk("s6_done_time", dn1_q[0] - e0, 18);
    chk("s6_period", e1 - e0, 20);
    chk("s6_toggles", t1_q.size(), 32);
    chk("s6_first_tog", t1_q[0] - e0, 2);
    nb = 0;
    for (int i = 1; i < 16; i++)
      if (t1_q[i] - t1_q[i-1] != 1) nb++;
    chk("s6_tog_spacing", nb, 0);
    chk("s6_second_tog", t1_q[16] - e1, 2);
    chk("s6_data_a", d1_q[0], 32'h5A);
    chk("s6_data_b", d1_q[1], 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
